// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage. ALU results pass straight through to the
// write-back bundle in one cycle. Aligned loads and stores are captured and
// held on the data-memory port until the memory acknowledges them.
// Misaligned memory ops are rejected with a one-cycle flag.
module mem_access_stage #(
    parameter int B = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    input  logic [B-1:0] alu_result,
    input  logic [B-1:0] write_data,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic         reg_write,
    input  logic         mem_to_reg,
    input  logic [4:0]   write_reg,
    output logic         stall,
    output logic         dmem_req,
    output logic         dmem_we,
    output logic [B-1:0] dmem_addr,
    output logic [B-1:0] dmem_wdata,
    input  logic         dmem_ack,
    input  logic [B-1:0] dmem_rdata,
    output logic         wb_valid,
    output logic         wb_reg_write,
    output logic [4:0]   wb_write_reg,
    output logic [B-1:0] wb_data,
    output logic         misaligned
);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t       state;
    logic [B-1:0] addr_q;
    logic [B-1:0] wdata_q;
    logic         we_q;
    logic         rw_q;
    logic         m2r_q;
    logic [4:0]   wreg_q;

    logic is_mem;
    logic aligned;

    // Decode the incoming op: any memory op, and word alignment of its address.
    always_comb begin
        is_mem  = mem_read | mem_write;
        aligned = (alu_result[1:0] == 2'b00);
    end

    // Memory port is driven only while waiting. Because it is decoded from the
    // asynchronously reset state, reset drops the request immediately.
    always_comb begin
        stall      = (state == WAIT);
        dmem_req   = (state == WAIT);
        dmem_we    = (state == WAIT) & we_q;
        dmem_addr  = (state == WAIT) ? addr_q  : '0;
        dmem_wdata = (state == WAIT) ? wdata_q : '0;
    end

    // Stage FSM: pass-through, capture, completion and the write-back registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            addr_q       <= '0;
            wdata_q      <= '0;
            we_q         <= 1'b0;
            rw_q         <= 1'b0;
            m2r_q        <= 1'b0;
            wreg_q       <= '0;
            wb_valid     <= 1'b0;
            wb_reg_write <= 1'b0;
            wb_write_reg <= '0;
            wb_data      <= '0;
            misaligned   <= 1'b0;
        end else begin
            // Pulses default low; wb_data and wb_write_reg keep their last value.
            wb_valid     <= 1'b0;
            wb_reg_write <= 1'b0;
            misaligned   <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (!is_mem) begin
                            wb_valid     <= 1'b1;
                            wb_data      <= alu_result;
                            wb_reg_write <= reg_write;
                            wb_write_reg <= write_reg;
                        end else if (aligned) begin
                            // A store wins when both read and write are set.
                            addr_q  <= alu_result;
                            wdata_q <= write_data;
                            we_q    <= mem_write;
                            rw_q    <= reg_write;
                            m2r_q   <= mem_to_reg;
                            wreg_q  <= write_reg;
                            state   <= WAIT;
                        end else begin
                            wb_valid   <= 1'b1;
                            misaligned <= 1'b1;
                        end
                    end
                end
                WAIT: begin
                    if (dmem_ack) begin
                        wb_valid     <= 1'b1;
                        wb_data      <= m2r_q ? dmem_rdata : addr_q;
                        wb_reg_write <= rw_q & ~we_q;
                        wb_write_reg <= wreg_q;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/mem_access_stage.md
MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 SHALL have parameter B, default 32, datapath width in bits.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  execute-stage result valid this cycle.
REQ-005 SHALL have port alu_result  input  B  execute-stage ALU result; memory byte address for loads/stores.
REQ-006 SHALL have port write_data  input  B  store data.
REQ-007 SHALL have ports mem_read, mem_write, reg_write, mem_to_reg  input  1 each  control bits carried from decode.
REQ-008 SHALL have port write_reg  input  5  destination register index.
REQ-009 SHALL have port stall  output  1  stage busy; upstream holds its outputs unchanged.
REQ-010 SHALL have ports dmem_req, dmem_we  output  1 each  data-memory request and write enable.
REQ-011 SHALL have ports dmem_addr, dmem_wdata  output  B each  memory address and store data.
REQ-012 SHALL have ports dmem_ack  input  1, dmem_rdata  input  B  memory completion and load data.
REQ-013 SHALL have ports wb_valid, wb_reg_write  output  1 each; wb_write_reg  output  5; wb_data  output  B  registered write-back bundle.
REQ-014 SHALL have port misaligned  output  1  one-cycle pulse on a rejected misaligned access.

Function
REQ-015 SHALL implement a two-state FSM: IDLE and WAIT.
REQ-016 In IDLE with in_valid=1 and mem_read=0 and mem_write=0: next edge sets wb_valid=1, wb_data=alu_result, wb_reg_write=reg_write, wb_write_reg=write_reg (latency 1); state stays IDLE.
REQ-017 In IDLE with in_valid=1, (mem_read|mem_write)=1 and alu_result[1:0]=00: next edge captures address, write data, mem_write, reg_write, mem_to_reg, write_reg; state goes to WAIT.
REQ-018 mem_write SHALL take priority when mem_read and mem_write are both 1; the op is a store.
REQ-019 Misaligned access (alu_result[1:0]!=00, memory op) SHALL issue no request; next edge sets wb_valid=1, wb_reg_write=0, misaligned=1 for one cycle; state stays IDLE.
REQ-020 In WAIT: dmem_req=1, dmem_we=captured mem_write, dmem_addr and dmem_wdata held stable from captured values until ack.
REQ-021 stall SHALL equal (state==WAIT); inputs are ignored while in WAIT.
REQ-022 On dmem_ack=1 in WAIT: next edge sets wb_valid=1, wb_data=dmem_rdata if mem_to_reg else captured address, wb_reg_write=captured reg_write (forced 0 for stores), returns to IDLE; minimum memory-op latency 2 cycles from acceptance.
REQ-023 dmem_ack SHALL be ignored in IDLE.
REQ-024 wb_valid and misaligned SHALL be single-cycle pulses; wb_data/wb_write_reg hold last value when wb_valid=0.
REQ-025 dmem_req, dmem_we SHALL be 0 in IDLE; dmem_addr/dmem_wdata SHALL be 0 in IDLE.
REQ-026 in_valid=0 in IDLE SHALL produce wb_valid=0 next cycle and no state change.

Reset
REQ-027 reset=1 SHALL immediately force state IDLE and all outputs 0 (stall, dmem_req, dmem_we, dmem_addr, dmem_wdata, wb_valid, wb_reg_write, wb_write_reg, wb_data, misaligned), independent of clk.
REQ-028 reset asserted in WAIT SHALL abort the access: dmem_req drops within the same cycle and no write-back is produced for the aborted op.
REQ-029 After reset deasserts, the first rising edge SHALL be evaluated from IDLE.

Verification
REQ-030 ALU op: in_valid=1, alu_result=0x0000_0007, reg_write=1, write_reg=5 -> next cycle wb_valid=1, wb_data=0x7, wb_write_reg=5, stall=0.
REQ-031 Load with 3-cycle ack: alu_result=0x100, mem_read=1, mem_to_reg=1, dmem_rdata=0xDEADBEEF on ack -> dmem_req=1, dmem_addr=0x100, stall=1 for 3 cycles; cycle after ack wb_data=0xDEADBEEF, wb_valid=1.
REQ-032 Store with same-cycle ack: alu_result=0x20, write_data=0xA5A5A5A5, mem_write=1, reg_write=1, dmem_ack=1 at first WAIT cycle -> dmem_we=1, dmem_wdata=0xA5A5A5A5 for 1 cycle; write-back wb_valid=1, wb_reg_write=0.
REQ-033 Misaligned: mem_read=1, alu_result=0x102 -> dmem_req never asserts; next cycle misaligned=1, wb_valid=1, wb_reg_write=0.
REQ-034 Reset mid-WAIT: load to 0x40, assert reset two cycles into WAIT -> dmem_req=0 and stall=0 immediately; no wb_valid after release; a later ALU op completes with latency 1.
REQ-035 Both mem_read=1 and mem_write=1 at 0x8 -> dmem_we=1 during WAIT, wb_reg_write=0 on completion.
